multiword_adder_ctrl: RTL and testbench

MULTIWORD_ADDER_CTRL -- requirements
Module: multiword_adder_ctrl

---
 rtl/multiword_adder_pkg.sv | 13 +
 rtl/carry_lookahead_adder.sv | 29 ++
 rtl/multiword_adder_ctrl.sv | 110 +++++++++++
 tb/tb_multiword_adder_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multiword_adder_pkg.sv
// Shared types and defaults for the multiword adder controller.
package multiword_adder_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned WORDS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/carry_lookahead_adder.sv
// WIDTH-bit adder built from generate/propagate terms with a carry in and carry out.
module carry_lookahead_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    logic carry;
    sum   = '0;
    carry = cin;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum[i] = p[i] ^ carry;
      carry  = g[i] | (p[i] & carry);
    end
    cout = carry;
  end

endmodule

// File: rtl/multiword_adder_ctrl.sv
// Sequential WIDTH*WORDS-bit adder: one shared WIDTH-bit adder, one word per cycle, LSB first.
// Define MULTIWORD_ADDER_SUB_EN to add the in_sub port (a + ~b + 1 when set).
module multiword_adder_ctrl
  import multiword_adder_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned WORDS = WORDS_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] in_a,
  input  logic [WIDTH*WORDS-1:0] in_b,
  input  logic                   in_carry,
`ifdef MULTIWORD_ADDER_SUB_EN
  input  logic                   in_sub,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] out_sum,
  output logic                   out_carry
);

  localparam int unsigned   IW   = $clog2(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  state_t state;
  state_t state_next;

  logic [IW-1:0]                idx;
  logic [WORDS-1:0][WIDTH-1:0]  a_reg;
  logic [WORDS-1:0][WIDTH-1:0]  b_reg;
  logic [WORDS-1:0][WIDTH-1:0]  sum_reg;
  logic                         carry_reg;
  logic                         carry_out_reg;
  logic [WIDTH-1:0]             b_word;
  logic [WIDTH-1:0]             add_sum;
  logic                         add_cout;

`ifdef MULTIWORD_ADDER_SUB_EN
  logic sub_reg;
  assign b_word = sub_reg ? ~b_reg[idx] : b_reg[idx];
`else
  assign b_word = b_reg[idx];
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_sum   = sum_reg;
  assign out_carry = carry_out_reg;

  carry_lookahead_adder #(.WIDTH(WIDTH)) u_cla (
    .a    (a_reg[idx]),
    .b    (b_word),
    .cin  (carry_reg),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid)    state_next = RUN;
      RUN:     if (idx == LAST) state_next = DONE;
      DONE:    if (out_ready)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx           <= '0;
      sum_reg       <= '0;
      carry_reg     <= 1'b0;
      carry_out_reg <= 1'b0;
`ifdef MULTIWORD_ADDER_SUB_EN
      sub_reg       <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          a_reg <= in_a;
          b_reg <= in_b;
          idx   <= '0;
`ifdef MULTIWORD_ADDER_SUB_EN
          // Subtraction seeds the chain with the +1 of two's complement.
          sub_reg   <= in_sub;
          carry_reg <= in_sub ? 1'b1 : in_carry;
`else
          carry_reg <= in_carry;
`endif
        end
        RUN: begin
          sum_reg[idx] <= add_sum;
          carry_reg    <= add_cout;
          idx          <= idx + IW'(1);
          if (idx == LAST) carry_out_reg <= add_cout;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_adder_ctrl.sv
// Self-checking bench for multiword_adder_ctrl (WIDTH=8, WORDS=4): vector table plus corner sequences.
module tb_multiword_adder_ctrl;

  localparam int unsigned W  = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned TW = W * N;

  typedef struct {
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic          cin;
    logic [TW-1:0] exp_sum;
    logic          exp_cout;
  } vec_t;

  typedef struct {
    logic [TW-1:0] sum;
    logic          cout;
  } res_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] in_a;
  logic [TW-1:0] in_b;
  logic          in_carry;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_sum;
  logic          out_carry;
`ifdef MULTIWORD_ADDER_SUB_EN
  logic          in_sub;
`endif

  int   n_cmp  = 0;
  int   n_fail = 0;
  res_t exp_q[$];
  time  acc_t;

  always #5 clk = ~clk;

  multiword_adder_ctrl #(.WIDTH(W), .WORDS(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_carry  (in_carry),
`ifdef MULTIWORD_ADDER_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  // Scoreboard sink: a handshake seen at a falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        timeout("unexpected result");
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check("sb sum", out_sum, e.sum);
        check("sb cout", out_carry, e.cout);
      end
    end
  end

  // Drives one request, pushes its expected result on accept, returns once out_valid is seen.
  task automatic send(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic cin,
                      input logic [TW-1:0] exp_sum, input logic exp_cout, input string tag);
    int   k;
    int   lat;
    res_t e;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_carry = cin;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) break;
      @(posedge clk); #1;
    end
    if (k == 20) begin
      timeout({tag, " accept"});
      in_valid = 1'b0;
      return;
    end
    e.sum  = exp_sum;
    e.cout = exp_cout;
    exp_q.push_back(e);
    @(posedge clk);
    acc_t = $time;
    #1;
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    in_carry = 1'($urandom);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
    end
    check({tag, " latency"}, lat, N);
  endtask

  initial begin
    vec_t          vecs[7];
    time           prev_t;
    logic [TW-1:0] held_sum;
    logic [TW:0]   model;
    logic [TW-1:0] ra;
    logic [TW-1:0] rb;
    logic          rc;
    int            seen;

    vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
    vecs[2] = '{32'h0102_0304, 32'h1020_3040, 1'b0, 32'h1122_3344, 1'b0};
    vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
    vecs[6] = '{32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 32'h2143_6588, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_carry  = 1'b0;
    out_ready = 1'b0;
`ifdef MULTIWORD_ADDER_SUB_EN
    in_sub    = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset out_sum", out_sum, 0);
    check("reset out_carry", out_carry, 0);

    // Table vectors back to back with the consumer always ready.
    out_ready = 1'b1;
    prev_t    = 0;
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_cout, $sformatf("vec%0d", i));
      check($sformatf("vec%0d sum", i), out_sum, vecs[i].exp_sum);
      check($sformatf("vec%0d cout", i), out_carry, vecs[i].exp_cout);
      if (i > 0) check($sformatf("vec%0d accept spacing", i), acc_t - prev_t, 60);
      prev_t = acc_t;
    end

    // Consumer stalls five cycles in DONE.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'h0A0B_0C0D, 32'h0101_0101, 1'b0, 32'h0B0C_0D0E, 1'b0, "stall");
    held_sum = out_sum;
    check("stall initial sum", held_sum, 32'h0B0C_0D0E);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall out_valid", out_valid, 1);
      check("stall out_sum", out_sum, 32'h0B0C_0D0E);
      check("stall in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("post-pulse in_ready", in_ready, 1);
    check("post-pulse out_valid", out_valid, 0);

    // Reset lands on the second RUN edge; the operation must vanish.
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_a     = 32'h5555_5555;
    in_b     = 32'h2222_2222;
    in_carry = 1'b1;
    @(negedge clk);
    check("abort accept in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort in_ready", in_ready, 1);
    check("abort out_valid", out_valid, 0);
    check("abort out_sum", out_sum, 0);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort no result", seen, 0);

    // Random operands against an arithmetic model.
    for (int r = 0; r < 6; r++) begin
      ra    = $urandom;
      rb    = $urandom;
      rc    = 1'($urandom);
      model = {1'b0, ra} + {1'b0, rb} + {{TW{1'b0}}, rc};
      send(ra, rb, rc, model[TW-1:0], model[TW], $sformatf("rand%0d", r));
    end

`ifdef MULTIWORD_ADDER_SUB_EN
    in_sub = 1'b1;
    send(32'h0000_0005, 32'h0000_0007, 1'b0, 32'hFFFF_FFFE, 1'b0, "sub borrow");
    send(32'h0000_0009, 32'h0000_0004, 1'b0, 32'h0000_0005, 1'b1, "sub no borrow");
    in_sub = 1'b0;
`endif

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
